// File: rtl/tl_cpl_gen.sv
// Completion generator: turns memory-read requests into Cpl/CplD beats.
// A header is emitted per chunk, followed by the line data read from local memory.
//
// state | meaning
// IDLE  | waiting for a request; output path fully drained
// HDR   | queue the completion header for the current chunk
// DATA  | issue one memory read per 16-byte beat of the chunk
module tl_cpl_gen #(
    parameter int          TAG_W          = 8,
    parameter logic [15:0] COMPLETER_ID   = 16'h0100,
    parameter int          MAX_PAYLOAD_DW = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      req_addr,
    input  logic [9:0]       req_len,
    input  logic [TAG_W-1:0] req_tag,
    input  logic [15:0]      req_rid,
    input  logic             req_valid,
    output logic             req_ready,
    output logic             mem_rd_en,
    output logic [27:0]      mem_rd_addr,
    input  logic [127:0]     mem_rd_data,
    output logic [127:0]     tx_data,
    output logic             tx_sop,
    output logic             tx_eop,
    output logic             tx_valid,
    input  logic             tx_ready
);
    typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;

    localparam logic [10:0] MAX_DW = 11'(MAX_PAYLOAD_DW);

    state_t       state;
    logic [31:0]  addr;
    logic [10:0]  rem;
    logic [7:0]   tag_q;
    logic [15:0]  rid_q;
    logic         bad;
    logic [8:0]   beat_cnt;

    logic         p_valid, p_hdr, p_sop, p_eop;
    logic [127:0] p_data;
    logic         sk_valid, sk_sop, sk_eop;
    logic [127:0] sk_data;

    logic [10:0]  chunk;
    logic [127:0] hdr;
    logic [127:0] push_data;
    logic [1:0]   fill;
    logic         pop, room, hdr_go, rd_go;

    always_comb begin
        chunk = (rem < MAX_DW) ? rem : MAX_DW;
        hdr = '0;
        hdr[31:29]  = 3'b010;
        hdr[28:24]  = 5'b01010;
        hdr[63:48]  = COMPLETER_ID;
        hdr[95:80]  = rid_q;
        hdr[79:72]  = tag_q;
        hdr[70:64]  = addr[6:0];
        if (bad) begin
            hdr[47:45] = 3'b001;
            hdr[43:32] = 12'd4;
        end else begin
            hdr[9:0]   = chunk[9:0];
            hdr[43:32] = {rem[9:0], 2'b00};
        end
    end

    // fill counts the beat in flight through the read-latency stage, so a new
    // op is only started when that beat is certain to find a free slot.
    assign pop         = tx_valid && tx_ready;
    assign fill        = 2'(tx_valid) + 2'(sk_valid) + 2'(p_valid);
    assign room        = (fill < 2'd2) || ((fill == 2'd2) && pop);
    assign hdr_go      = (state == HDR) && room;
    assign rd_go       = (state == DATA) && room;
    assign mem_rd_en   = rd_go;
    assign mem_rd_addr = addr[31:4];
    assign req_ready   = (state == IDLE) && !tx_valid && !p_valid;
    assign push_data   = p_hdr ? p_data : mem_rd_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            addr     <= '0;
            rem      <= '0;
            tag_q    <= '0;
            rid_q    <= '0;
            bad      <= 1'b0;
            beat_cnt <= '0;
        end else begin
            case (state)
                IDLE: if (req_valid && req_ready) begin
                    addr  <= req_addr;
                    rem   <= (req_len == 10'd0) ? 11'd1024 : {1'b0, req_len};
                    tag_q <= 8'(req_tag);
                    rid_q <= req_rid;
                    bad   <= (req_addr[3:0] != 4'd0) || (req_len[1:0] != 2'd0);
                    state <= HDR;
                end
                HDR: if (hdr_go) begin
                    if (bad) begin
                        state <= IDLE;
                    end else begin
                        beat_cnt <= chunk[10:2];
                        rem      <= rem - chunk;
                        state    <= DATA;
                    end
                end
                DATA: if (rd_go) begin
                    addr     <= addr + 32'd16;
                    beat_cnt <= beat_cnt - 9'd1;
                    if (beat_cnt == 9'd1)
                        state <= (rem != 11'd0) ? HDR : IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Stage aligned with the one-cycle memory latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_valid <= 1'b0;
            p_hdr   <= 1'b0;
            p_sop   <= 1'b0;
            p_eop   <= 1'b0;
            p_data  <= '0;
        end else begin
            p_valid <= hdr_go || rd_go;
            p_hdr   <= hdr_go;
            p_sop   <= hdr_go;
            p_eop   <= hdr_go ? bad : (beat_cnt == 9'd1);
            if (hdr_go)
                p_data <= hdr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_valid <= 1'b0;
            tx_data  <= '0;
            tx_sop   <= 1'b0;
            tx_eop   <= 1'b0;
            sk_valid <= 1'b0;
            sk_data  <= '0;
            sk_sop   <= 1'b0;
            sk_eop   <= 1'b0;
        end else if (!tx_valid || pop) begin
            if (sk_valid) begin
                tx_valid <= 1'b1;
                tx_data  <= sk_data;
                tx_sop   <= sk_sop;
                tx_eop   <= sk_eop;
                sk_valid <= p_valid;
                sk_data  <= push_data;
                sk_sop   <= p_sop;
                sk_eop   <= p_eop;
            end else begin
                tx_valid <= p_valid;
                if (p_valid) begin
                    tx_data <= push_data;
                    tx_sop  <= p_sop;
                    tx_eop  <= p_eop;
                end
            end
        end else if (p_valid) begin
            sk_valid <= 1'b1;
            sk_data  <= push_data;
            sk_sop   <= p_sop;
            sk_eop   <= p_eop;
        end
    end
endmodule
